// File: rtl/clk_divider_prog.sv
// Programmable divider: tick/clk_out register on the edge that samples count==cur_div, (cur_div+1) enabled cycles apart.
// No backpressure; divisor reloads wait for a period boundary unless the counter is frozen or cleared.
module clk_divider_prog #(
   parameter int CNT_W   = 16,
   parameter int DEF_DIV = 62499
) (
   input  logic             clk_50M,
   input  logic             ncr,
   input  logic             en,
   input  logic             clr,
   input  logic             mode,
   input  logic [CNT_W-1:0] div_val,
   input  logic             div_load,
   output logic             clk_out,
   output logic             tick,
   output logic             div_busy,
   output logic [CNT_W-1:0] cur_div
);

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] pend_div;
   logic             term;

   assign term = en & (count == cur_div);

   always_ff @(posedge clk_50M or negedge ncr) begin
      if (!ncr) begin
         count    <= '0;
         clk_out  <= 1'b0;
         tick     <= 1'b0;
         div_busy <= 1'b0;
         pend_div <= '0;
         cur_div  <= CNT_W'(DEF_DIV);
      end else if (clr) begin
         count   <= '0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
         // A same-cycle load beats any divisor still waiting to be applied.
         if (div_load) begin
            cur_div  <= div_val;
            div_busy <= 1'b0;
         end else if (div_busy) begin
            cur_div  <= pend_div;
            div_busy <= 1'b0;
         end
      end else if (!en) begin
         tick <= 1'b0;
         if (mode)
            clk_out <= 1'b0;
         if (div_load) begin
            cur_div  <= div_val;
            count    <= '0;
            div_busy <= 1'b0;
         end
      end else begin
         tick    <= term;
         clk_out <= mode ? term : (clk_out ^ term);
         if (term) begin
            count <= '0;
            // Boundary: the new divisor takes effect for the period starting now.
            if (div_load) begin
               cur_div  <= div_val;
               div_busy <= 1'b0;
            end else if (div_busy) begin
               cur_div  <= pend_div;
               div_busy <= 1'b0;
            end
         end else begin
            count <= count + CNT_W'(1);
            if (div_load) begin
               pend_div <= div_val;
               div_busy <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_clk_divider_prog.sv
// Directed bench for clk_divider_prog (CNT_W=4, DEF_DIV=3) with a period-level reference model.
module tb_clk_divider_prog;

   logic       clk_50M = 1'b0;
   logic       ncr;
   logic       en;
   logic       clr;
   logic       mode;
   logic [3:0] div_val;
   logic       div_load;
   logic       clk_out;
   logic       tick;
   logic       div_busy;
   logic [3:0] cur_div;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_on = 1'b0;

   // Reference state: position within the current period, divisor in force, pending divisor.
   int m_pos;
   int m_cur;
   int m_pend;
   bit m_pend_vld;
   bit m_tick;
   bit m_lvl;

   clk_divider_prog #(.CNT_W(4), .DEF_DIV(3)) dut (
      .clk_50M (clk_50M),
      .ncr     (ncr),
      .en      (en),
      .clr     (clr),
      .mode    (mode),
      .div_val (div_val),
      .div_load(div_load),
      .clk_out (clk_out),
      .tick    (tick),
      .div_busy(div_busy),
      .cur_div (cur_div)
   );

   always #10 clk_50M = ~clk_50M;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic mdl_reset();
      m_pos      = 0;
      m_cur      = 3;
      m_pend     = 0;
      m_pend_vld = 1'b0;
      m_tick     = 1'b0;
      m_lvl      = 1'b0;
   endtask

   always @(negedge ncr) mdl_reset();

   always @(posedge clk_50M) begin
      if (ncr !== 1'b1) begin
         mdl_reset();
      end else if (clr) begin
         m_pos  = 0;
         m_lvl  = 1'b0;
         m_tick = 1'b0;
         if (div_load) begin
            m_cur      = int'(div_val);
            m_pend_vld = 1'b0;
         end else if (m_pend_vld) begin
            m_cur      = m_pend;
            m_pend_vld = 1'b0;
         end
      end else if (!en) begin
         m_tick = 1'b0;
         if (mode) m_lvl = 1'b0;
         if (div_load) begin
            m_cur      = int'(div_val);
            m_pos      = 0;
            m_pend_vld = 1'b0;
         end
      end else begin
         // A period lasts m_cur+1 enabled cycles; the last one is the boundary.
         bit last;
         last   = (m_pos + 1 == m_cur + 1);
         m_tick = last;
         m_lvl  = mode ? last : (m_lvl ^ last);
         if (last) begin
            m_pos = 0;
            if (div_load) begin
               m_cur      = int'(div_val);
               m_pend_vld = 1'b0;
            end else if (m_pend_vld) begin
               m_cur      = m_pend;
               m_pend_vld = 1'b0;
            end
         end else begin
            m_pos = m_pos + 1;
            if (div_load) begin
               m_pend     = int'(div_val);
               m_pend_vld = 1'b1;
            end
         end
      end
   end

   always @(posedge clk_50M) begin
      #1;
      if (chk_on) begin
         chk("mdl_tick", 32'(tick), 32'(m_tick));
         chk("mdl_clk_out", 32'(clk_out), 32'(m_lvl));
         chk("mdl_div_busy", 32'(div_busy), 32'(m_pend_vld));
         chk("mdl_cur_div", 32'(cur_div), 32'(m_cur));
      end
   end

   task automatic load(input logic [3:0] v);
      div_val  = v;
      div_load = 1'b1;
      @(negedge clk_50M);
      div_load = 1'b0;
   endtask

   initial begin
      ncr = 1'b0; en = 1'b0; clr = 1'b0; mode = 1'b0; div_val = '0; div_load = 1'b0;
      repeat (2) @(negedge clk_50M);
      chk("rst_tick", 32'(tick), 0);
      chk("rst_clk_out", 32'(clk_out), 0);
      chk("rst_busy", 32'(div_busy), 0);
      chk("rst_cur_div", 32'(cur_div), 3);
      chk_on = 1'b1;

      // Toggle mode: ticks at enabled edges 4, 8, 12; square wave of period 8.
      ncr = 1'b1; en = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk_50M);
         chk("t1_tick", 32'(tick), 32'(i % 4 == 0));
         chk("t1_clk_out", 32'(clk_out), 32'((i / 4) % 2));
      end

      // Pulse mode: clk_out follows tick, one cycle in four.
      mode = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk_50M);
         chk("t2_tick", 32'(tick), 32'(i % 4 == 0));
         chk("t2_clk_out", 32'(clk_out), 32'(i % 4 == 0));
      end

      // Deferred reload, last write wins, coincident load.
      mode = 1'b0;
      @(negedge clk_50M);
      load(4'd1);
      chk("t3_busy_set", 32'(div_busy), 1);
      chk("t3_cur_old", 32'(cur_div), 3);
      @(negedge clk_50M);
      chk("t3_busy_hold", 32'(div_busy), 1);
      chk("t3_no_runt", 32'(tick), 0);
      @(negedge clk_50M);
      chk("t3_tick_old_period", 32'(tick), 1);
      chk("t3_cur_applied", 32'(cur_div), 1);
      chk("t3_busy_clr", 32'(div_busy), 0);
      @(negedge clk_50M);
      chk("t3_p2_gap", 32'(tick), 0);
      @(negedge clk_50M);
      chk("t3_p2_tick", 32'(tick), 1);
      load(4'd3);
      chk("t3_pend3", 32'(div_busy), 1);
      load(4'd2);
      chk("t3_coinc_cur", 32'(cur_div), 2);
      chk("t3_coinc_busy", 32'(div_busy), 0);
      chk("t3_coinc_tick", 32'(tick), 1);
      load(4'd5);
      load(4'd1);
      @(negedge clk_50M);
      chk("t3_lww_tick", 32'(tick), 1);
      chk("t3_lww_cur", 32'(cur_div), 1);

      // Divisor 0: tick stuck high, clk_out at half the clock rate.
      load(4'd0);
      @(negedge clk_50M);
      chk("t4_cur0", 32'(cur_div), 0);
      chk("t4_clk_out0", 32'(clk_out), 0);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk_50M);
         chk("t4_tick", 32'(tick), 1);
         chk("t4_clk_out", 32'(clk_out), 32'(i % 2));
      end

      // Freeze, then load while frozen.
      en = 1'b0;
      load(4'd3);
      chk("t5_frozen_load", 32'(cur_div), 3);
      en = 1'b1;
      repeat (2) @(negedge clk_50M);
      en = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk_50M);
         chk("t5_frz_tick", 32'(tick), 0);
         chk("t5_frz_clk_out", 32'(clk_out), 0);
      end
      en = 1'b1;
      @(negedge clk_50M);
      chk("t5_resume_cnt3", 32'(tick), 0);
      @(negedge clk_50M);
      chk("t5_resume_tick", 32'(tick), 1);
      chk("t5_resume_clk", 32'(clk_out), 1);
      en = 1'b0;
      load(4'd5);
      chk("t5_load5", 32'(cur_div), 5);
      en = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk_50M);
         chk("t5_p6_tick", 32'(tick), 32'(i == 6));
      end

      // Asynchronous reset mid-period with a pending divisor.
      load(4'd6);
      @(negedge clk_50M);
      chk("t6_busy_pre", 32'(div_busy), 1);
      ncr = 1'b0;
      #1;
      chk("t6_rst_clk_out", 32'(clk_out), 0);
      chk("t6_rst_cur", 32'(cur_div), 3);
      chk("t6_rst_busy", 32'(div_busy), 0);
      chk("t6_rst_tick", 32'(tick), 0);
      @(negedge clk_50M);
      ncr = 1'b1;

      // Synchronous clear applies the pending divisor.
      load(4'd6);
      @(negedge clk_50M);
      clr = 1'b1;
      @(negedge clk_50M);
      clr = 1'b0;
      chk("t6_clr_cur", 32'(cur_div), 6);
      chk("t6_clr_busy", 32'(div_busy), 0);
      chk("t6_clr_clk_out", 32'(clk_out), 0);
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk_50M);
         chk("t6_p7_tick", 32'(tick), 32'(i == 7));
      end
      clr = 1'b1;
      load(4'd2);
      clr = 1'b0;
      chk("t6_clr_load_cur", 32'(cur_div), 2);
      chk("t6_clr_load_clk", 32'(clk_out), 0);
      repeat (2) @(negedge clk_50M);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
